tmds_encoder: RTL

- Downstream neighbour of the axis-to-native converter.
- Consumes the native video stream it produces (24-bit pixel, hsync, vsync, active) and emits three 10-bit TMDS symbol lanes for the HDMI serializer.
- Implements DVI 1.0 8b/10b with running-disparity balancing and control-period encoding. An optional HDMI video preamble/guard band can be compiled in.

---
 rtl/tmds_pkg.sv | 45 ++++
 rtl/tmds_channel_enc.sv | 66 ++++++
 rtl/tmds_encoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants and types for the DVI/HDMI lane encoder.
// Optional HDMI preamble/guard band: define TMDS_HDMI_GUARD_EN.
package tmds_pkg;

   typedef logic [9:0] tmds_sym_t;

   localparam tmds_sym_t CTRL_00 = 10'h354;
   localparam tmds_sym_t CTRL_01 = 10'h0AB;
   localparam tmds_sym_t CTRL_10 = 10'h154;
   localparam tmds_sym_t CTRL_11 = 10'h2AB;

   localparam tmds_sym_t GUARD_VID_CH0 = 10'h2CC;
   localparam tmds_sym_t GUARD_VID_CH1 = 10'h133;
   localparam tmds_sym_t GUARD_VID_CH2 = 10'h2CC;

`ifdef TMDS_HDMI_GUARD_EN
   localparam int GUARD_DELAY = 10;
   localparam int LATENCY     = 12;
`else
   localparam int LATENCY     = 2;
`endif

   typedef enum logic [1:0] {
      GK_NONE,
      GK_PREAMBLE,
      GK_GUARD
   } guard_kind_t;

   typedef struct packed {
      logic [23:0] data;
      logic        hsync;
      logic        vsync;
      logic        active;
   } natv_beat_t;

   function automatic tmds_sym_t ctrl_code(input logic [1:0] c);
      case (c)
         2'b00:   return CTRL_00;
         2'b01:   return CTRL_01;
         2'b10:   return CTRL_10;
         default: return CTRL_11;
      endcase
   endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS lane: transition-minimising stage and DC-balancing stage in a
// single registered step; owns the lane's running disparity counter.
module tmds_channel_enc
   import tmds_pkg::*;
(
   input  logic       natv_clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       de,
   input  logic [1:0] ctrl,
   output tmds_sym_t  sym
);

   function automatic logic [8:0] min_transition(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n1;
      logic       use_xnor;
      n1       = 4'($countones(d));
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q[0]     = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8]     = ~use_xnor;
      return q;
   endfunction

   // Counter is 6 bits so the full -16..+16 span is representable without wrap.
   logic signed [5:0] cnt, cnt_d;
   logic signed [5:0] diff;
   logic        [8:0] q_m;
   logic        [3:0] n1q;
   tmds_sym_t         sym_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      sym_d = ctrl_code(ctrl);
      cnt_d = '0;
      q_m   = min_transition(data);
      n1q   = 4'($countones(q_m[7:0]));
      diff  = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
      if (de) begin
         if (cnt == 6'sd0 || diff == 6'sd0) begin
            sym_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_d = cnt + (q_m[8] ? diff : -diff);
         end else if ((cnt > 6'sd0 && diff > 6'sd0) || (cnt < 6'sd0 && diff < 6'sd0)) begin
            sym_d = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_d = cnt + (q_m[8] ? 6'sd2 : 6'sd0) - diff;
         end else begin
            sym_d = {1'b0, q_m[8], q_m[7:0]};
            cnt_d = cnt - (q_m[8] ? 6'sd0 : 6'sd2) + diff;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all lanes update together.
   always_ff @(posedge natv_clk) begin
      if (!rst_n) begin
         sym <= CTRL_00;
         cnt <= '0;
      end else begin
         sym <= sym_d;
         cnt <= cnt_d;
      end
   end

endmodule

// File: rtl/tmds_encoder.sv
// Three-lane DVI TMDS encoder fed by the native video stream.
// Define TMDS_HDMI_GUARD_EN for the HDMI video preamble and guard band.
module tmds_encoder
   import tmds_pkg::*;
#(
   parameter int DWID     = 24,
   parameter bit SYNC_INV = 1'b0
) (
   input  logic            natv_clk,
   input  logic            rst_n,
   input  logic [DWID-1:0] natv_data,
   input  logic            natv_hsync,
   input  logic            natv_vsync,
   input  logic            natv_active,
   output logic [9:0]      tmds_ch0,
   output logic [9:0]      tmds_ch1,
   output logic [9:0]      tmds_ch2,
   output logic            tmds_de
);

   natv_beat_t in_q;
   natv_beat_t enc_in;
   tmds_sym_t  sym0, sym1, sym2;
   logic       de_q;

   // Sync polarity is fixed up before registering so reset leaves ctrl code 00.
   always_ff @(posedge natv_clk) begin
      if (!rst_n) begin
         in_q <= '0;
      end else begin
         in_q.data   <= natv_data;
         in_q.hsync  <= natv_hsync ^ SYNC_INV;
         in_q.vsync  <= natv_vsync ^ SYNC_INV;
         in_q.active <= natv_active;
      end
   end

`ifdef TMDS_HDMI_GUARD_EN
   natv_beat_t  dly [GUARD_DELAY];
   logic [3:0]  blank_cnt;
   logic [3:0]  seq_cnt;
   logic [3:0]  slot_pos;
   logic        rise;
   guard_kind_t kind, kind_q;

   // slot_pos counts down the slots still ahead of the first pixel of the line.
   always_comb begin
      rise     = in_q.active && (blank_cnt == 4'(GUARD_DELAY));
      slot_pos = rise ? 4'(GUARD_DELAY) : seq_cnt;
      kind     = GK_NONE;
      if (slot_pos >= 4'd3)
         kind = GK_PREAMBLE;
      else if (slot_pos != 4'd0)
         kind = GK_GUARD;
   end

   always_ff @(posedge natv_clk) begin
      if (!rst_n) begin
         // NOTE: the delay line is reset so no stale pixel escapes after reset release.
         for (int i = 0; i < GUARD_DELAY; i++)
            dly[i] <= '0;
         blank_cnt <= '0;
         seq_cnt   <= '0;
         kind_q    <= GK_NONE;
      end else begin
         dly[0] <= in_q;
         for (int i = 1; i < GUARD_DELAY; i++)
            dly[i] <= dly[i-1];
         if (in_q.active)
            blank_cnt <= '0;
         else if (blank_cnt != 4'(GUARD_DELAY))
            blank_cnt <= blank_cnt + 4'd1;
         if (rise)
            seq_cnt <= 4'(GUARD_DELAY - 1);
         else if (seq_cnt != 4'd0)
            seq_cnt <= seq_cnt - 4'd1;
         kind_q <= kind;
      end
   end

   assign enc_in = dly[GUARD_DELAY-1];

   always_comb begin
      tmds_ch0 = sym0;
      tmds_ch1 = sym1;
      tmds_ch2 = sym2;
      case (kind_q)
         GK_PREAMBLE: begin
            tmds_ch1 = CTRL_01;
            tmds_ch2 = CTRL_00;
         end
         GK_GUARD: begin
            tmds_ch0 = GUARD_VID_CH0;
            tmds_ch1 = GUARD_VID_CH1;
            tmds_ch2 = GUARD_VID_CH2;
         end
         default: ;
      endcase
   end
`else
   assign enc_in   = in_q;
   assign tmds_ch0 = sym0;
   assign tmds_ch1 = sym1;
   assign tmds_ch2 = sym2;
`endif

   always_ff @(posedge natv_clk) begin
      if (!rst_n)
         de_q <= 1'b0;
      else
         de_q <= enc_in.active;
   end

   assign tmds_de = de_q;

   tmds_channel_enc u_enc0 (
      .natv_clk (natv_clk),
      .rst_n    (rst_n),
      .data     (enc_in.data[7:0]),
      .de       (enc_in.active),
      .ctrl     ({enc_in.vsync, enc_in.hsync}),
      .sym      (sym0)
   );

   tmds_channel_enc u_enc1 (
      .natv_clk (natv_clk),
      .rst_n    (rst_n),
      .data     (enc_in.data[15:8]),
      .de       (enc_in.active),
      .ctrl     (2'b00),
      .sym      (sym1)
   );

   tmds_channel_enc u_enc2 (
      .natv_clk (natv_clk),
      .rst_n    (rst_n),
      .data     (enc_in.data[23:16]),
      .de       (enc_in.active),
      .ctrl     (2'b00),
      .sym      (sym2)
   );

endmodule
